// File: rtl/timer_counter_pkg.sv
// Shared definitions for the bus-mapped down-counting timer: state encoding,
// register word indices, MODE values and CTRL bit positions.
package timer_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_W        = 4;

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped 32-bit down counter with one-shot / auto-reload modes and a
// maskable interrupt. FSM state and raw irq flag are exported for debug.
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic [1:0]  A,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic [1:0]  dbg_state_o,
   output logic        dbg_irq_flag_o
);

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [31:0]         preset_q, preset_d;
   logic [31:0]         count_q, count_d;
   logic                irq_flag_q, irq_flag_d;
   logic                irq_set;
   logic                en;
   logic [1:0]          mode;

   assign en   = ctrl_q[CTRL_EN_BIT];
   assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;
      irq_set    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               // Terminal count: 0 and 1 both expire here, so COUNT never wraps.
               count_d = '0;
               irq_set = 1'b1;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            if (mode == MODE_RELOAD) begin
               irq_flag_d = 1'b0;
               state_d    = en ? ST_LOAD : ST_IDLE;
            end else begin
               ctrl_d[CTRL_EN_BIT] = 1'b0;
               state_d             = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes come after the FSM so a CTRL write overrides the EN clear.
      if (WE) begin
         case (A)
            REG_CTRL: begin
               ctrl_d     = Din[CTRL_W-1:0];
               irq_flag_d = 1'b0;
            end
            REG_PRESET: begin
               preset_d   = Din;
               irq_flag_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (irq_set) irq_flag_d = 1'b1;
   end

   always_comb begin
      Dout = '0;
      case (A)
         REG_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
         REG_PRESET: Dout = preset_q;
         REG_COUNT:  Dout = count_q;
         default:    Dout = '0;
      endcase
   end

   assign IRQ            = irq_flag_q & ctrl_q[CTRL_IM_BIT];
   assign dbg_state_o    = state_q;
   assign dbg_irq_flag_o = irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a per-cycle register-access vector table
// followed by hand-written multi-cycle counting, interrupt and reset sequences.
module tb_timer_counter;

   localparam logic [1:0] ST_IDLE = 2'd0;

   logic        clk;
   logic        rst;
   logic        WE;
   logic [1:0]  A;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic [1:0]  dbg_state;
   logic        dbg_flag;

   int n_cmp = 0;
   int n_err = 0;

   timer_counter dut (
      .clk            (clk),
      .rst            (rst),
      .WE             (WE),
      .A              (A),
      .Din            (Din),
      .Dout           (Dout),
      .IRQ            (IRQ),
      .dbg_state_o    (dbg_state),
      .dbg_irq_flag_o (dbg_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  a;
      logic [31:0] din;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      WE = 1'b0;
      A  = a;
      #1;
      chk(name, Dout, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      A   = a;
      Din = d;
      WE  = 1'b1;
      @(posedge clk);
      #1;
      WE  = 1'b0;
   endtask

   task automatic do_reset();
      WE  = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0};
      vecs[4]  = '{1'b1, 2'd1, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 2'd1, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 32'hFFFFFFF6, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 2'd0, 32'h0,        32'h6,        1'b0};
      vecs[8]  = '{1'b1, 2'd2, 32'h1234,     32'h0,        1'b0};
      vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0};
      vecs[10] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0};
      vecs[12] = '{1'b0, 2'd1, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[13] = '{1'b1, 2'd0, 32'h0,        32'h6,        1'b0};
      vecs[14] = '{1'b0, 2'd0, 32'h0,        32'h0,        1'b0};

      rst = 1'b0; WE = 1'b0; A = 2'd0; Din = '0;
      tick(2);
      rst = 1'b1;
      chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk("reset_irq", {31'd0, IRQ}, 32'd0);

      // Register access table; EN never set so the FSM stays idle.
      for (int i = 0; i < 15; i++) begin
         WE  = vecs[i].we;
         A   = vecs[i].a;
         Din = vecs[i].din;
         #1;
         chk($sformatf("vec%0d_dout", i), Dout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].exp_irq});
         @(posedge clk);
         #1;
      end
      WE = 1'b0;

      // One-shot PRESET=5: IRQ rises after edge 7 and stays.
      do_reset();
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         chk($sformatf("os_irq_e%0d", e), {31'd0, IRQ}, {31'd0, (e >= 7)});
         chk_rd($sformatf("os_cnt_e%0d", e), 2'd2, (e < 2) ? 32'd0 : (e == 7) ? 32'd0 : 32'(7 - e));
      end
      tick(3);
      chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
      chk_rd("os_ctrl", 2'd0, 32'h8);
      chk_rd("os_count", 2'd2, 32'd0);

      // Rewriting CTRL clears the flag; IRQ returns 7 edges later.
      wr(2'd0, 32'h9);
      chk("clr_irq_e0", {31'd0, IRQ}, 32'd0);
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         chk($sformatf("clr_irq_e%0d", e), {31'd0, IRQ}, {31'd0, (e == 7)});
      end

      // Auto-reload PRESET=3: 1-cycle pulse every 5 cycles.
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int e = 1; e <= 16; e++) begin
         int k;
         logic [31:0] exp_cnt;
         tick(1);
         k = (e - 2) % 5;
         exp_cnt = (e < 2) ? 32'd0 : (k == 4) ? 32'd0 : 32'(3 - k);
         chk($sformatf("ar_irq_e%0d", e), {31'd0, IRQ}, {31'd0, (e >= 5) && ((e - 5) % 5 == 0)});
         chk_rd($sformatf("ar_cnt_e%0d", e), 2'd2, exp_cnt);
      end

      // Abort at COUNT=40; a PRESET write mid-count waits for the next LOAD.
      do_reset();
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h9);
      tick(10);
      chk_rd("ab_cnt_e10", 2'd2, 32'd92);
      wr(2'd1, 32'd7);
      chk_rd("ab_cnt_after_preset", 2'd2, 32'd91);
      tick(50);
      chk_rd("ab_cnt_e61", 2'd2, 32'd41);
      wr(2'd0, 32'h8);
      chk_rd("ab_cnt_e62", 2'd2, 32'd40);
      tick(1);
      chk("ab_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      tick(5);
      chk_rd("ab_cnt_hold", 2'd2, 32'd40);
      chk("ab_irq", {31'd0, IRQ}, 32'd0);
      chk("ab_state_hold", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      wr(2'd0, 32'h9);
      tick(2);
      chk_rd("ab_reload_new_preset", 2'd2, 32'd7);

      // Masked, PRESET=0: flag set after edge 3, IRQ stays low.
      do_reset();
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      tick(2);
      chk("mk_flag_e2", {31'd0, dbg_flag}, 32'd0);
      tick(1);
      chk("mk_flag_e3", {31'd0, dbg_flag}, 32'd1);
      chk("mk_irq_e3", {31'd0, IRQ}, 32'd0);
      tick(1);
      chk("mk_flag_e4", {31'd0, dbg_flag}, 32'd1);
      wr(2'd0, 32'h9);
      chk("mk_irq_after_unmask", {31'd0, IRQ}, 32'd0);
      chk("mk_flag_after_unmask", {31'd0, dbg_flag}, 32'd0);

      // PRESET=1: same-edge set beats write clear; CTRL write beats EN clear.
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      tick(2);
      chk("p1_irq_e2", {31'd0, IRQ}, 32'd0);
      chk_rd("p1_cnt_e2", 2'd2, 32'd1);
      wr(2'd1, 32'd1);
      chk("p1_set_wins", {31'd0, IRQ}, 32'd1);
      wr(2'd0, 32'hD);
      chk("p1_irq_cleared", {31'd0, IRQ}, 32'd0);
      chk_rd("p1_ctrl_write_wins", 2'd0, 32'hD);
      chk("p1_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      tick(2);
      chk("p1_irq_e6", {31'd0, IRQ}, 32'd0);
      tick(1);
      chk("p1_irq_e7", {31'd0, IRQ}, 32'd1);
      tick(1);
      chk_rd("p1_mode10_oneshot", 2'd0, 32'hC);
      chk("p1_irq_e8", {31'd0, IRQ}, 32'd1);

      // Reset mid-count overrides a simultaneous PRESET write.
      do_reset();
      wr(2'd1, 32'd30);
      wr(2'd0, 32'h9);
      tick(15);
      chk_rd("rs_cnt_17", 2'd2, 32'd17);
      rst = 1'b0; WE = 1'b1; A = 2'd1; Din = 32'd55;
      @(posedge clk);
      #1;
      rst = 1'b1; WE = 1'b0;
      chk_rd("rs_ctrl", 2'd0, 32'd0);
      chk_rd("rs_preset", 2'd1, 32'd0);
      chk_rd("rs_count", 2'd2, 32'd0);
      chk("rs_irq", {31'd0, IRQ}, 32'd0);
      chk("rs_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      tick(3);
      chk_rd("rs_count_stays", 2'd2, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
